systolic_skew_feeder: RTL and testbench

- Upstream stage of the systolic PE array; drives the fire/activation/weight inputs of the array's edge PEs.
- Accepts one N-lane vector of activations and weights per beat over a valid/ready handshake.
- Re-times lane i by i cycles (diagonal skew) so operands meet correctly inside the array.
- Sequences a tile (beats up to in_last), flushes the skew pipeline, then pulses done.

---
 rtl/systolic_skew_feeder_pkg.sv | 20 ++
 rtl/systolic_skew_feeder_skew_delay_line.sv | 46 ++++
 rtl/systolic_skew_feeder.sv | 129 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and defaults for the systolic skew feeder and the PE array top.
// Holds the feeder state encoding and the lane slicing helper.
package systolic_skew_feeder_pkg;

  localparam int unsigned DEF_N  = 4;
  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } feeder_state_e;

  // LSB of lane `lane` inside a packed N*dw operand bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// D-stage delay line carrying fire plus one activation and one weight lane.
// Synchronous active-low reset clears every stage so an aborted tile leaves no residue.
module skew_delay_line #(
  parameter int unsigned D  = 1,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fire_in,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] w_in,
  output logic          fire_out,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] w_out
);

  logic          fire_q [D];
  logic [DW-1:0] a_q    [D];
  logic [DW-1:0] w_q    [D];

  // NOTE: every stage is reset, not just fire; stale data must not leak out after a mid-tile reset.
  // NOTE: non-blocking assignments keep the shift order-independent within the loop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < int'(D); k++) begin
        fire_q[k] <= 1'b0;
        a_q[k]    <= '0;
        w_q[k]    <= '0;
      end
    end else begin
      fire_q[0] <= fire_in;
      a_q[0]    <= a_in;
      w_q[0]    <= w_in;
      for (int k = 1; k < int'(D); k++) begin
        fire_q[k] <= fire_q[k-1];
        a_q[k]    <= a_q[k-1];
        w_q[k]    <= w_q[k-1];
      end
    end
  end

  assign fire_out = fire_q[D-1];
  assign a_out    = a_q[D-1];
  assign w_out    = w_q[D-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew operand feeder for the systolic PE array: lane i is delayed i+1 cycles.
// Optional SYSTOLA_FEEDER_ZERO_GATE_EN zeroes lane data on any lane whose fire is low.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_w,
  output logic [N-1:0]    lane_fire,
  output logic [N*DW-1:0] lane_a,
  output logic [N*DW-1:0] lane_w,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   tile_beats
);

  // Flush counter counts N-2 down to 0, giving N-1 bubble cycles after the last beat.
  localparam int unsigned   FCW         = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'((N > 1) ? (N - 2) : 0);
  localparam bit            SINGLE_LANE = (N == 1);

  feeder_state_e  state_q, state_d;
  logic [FCW-1:0] flush_q, flush_d;
  logic           done_q, done_d;
  logic [CW-1:0]  beats_q;
  logic           accept;

  assign in_ready = (state_q != ST_FLUSH);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      flush_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (!in_last) begin
            state_d = ST_STREAM;
          end else if (SINGLE_LANE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FLUSH;
            flush_d = FLUSH_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat counter restarts on the first accept of a tile and is held between tiles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beats_q <= '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        beats_q <= CW'(1);
      end else if (beats_q != '1) begin
        beats_q <= beats_q + 1'b1;
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign tile_beats = beats_q;

  logic [N-1:0]    fire_raw;
  logic [N*DW-1:0] a_raw;
  logic [N*DW-1:0] w_raw;

  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    skew_delay_line #(
      .D  (i + 1),
      .DW (DW)
    ) u_delay (
      .clk      (clk),
      .rstn     (rstn),
      .fire_in  (accept),
      .a_in     (in_a[lane_lsb(i, DW) +: DW]),
      .w_in     (in_w[lane_lsb(i, DW) +: DW]),
      .fire_out (fire_raw[i]),
      .a_out    (a_raw[lane_lsb(i, DW) +: DW]),
      .w_out    (w_raw[lane_lsb(i, DW) +: DW])
    );

`ifdef SYSTOLA_FEEDER_ZERO_GATE_EN
    assign lane_a[lane_lsb(i, DW) +: DW] = fire_raw[i] ? a_raw[lane_lsb(i, DW) +: DW] : '0;
    assign lane_w[lane_lsb(i, DW) +: DW] = fire_raw[i] ? w_raw[lane_lsb(i, DW) +: DW] : '0;
`else
    assign lane_a[lane_lsb(i, DW) +: DW] = a_raw[lane_lsb(i, DW) +: DW];
    assign lane_w[lane_lsb(i, DW) +: DW] = w_raw[lane_lsb(i, DW) +: DW];
`endif
  end

  assign lane_fire = fire_raw;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: directed tiles then random traffic against a history-based model.
// A CW=2 instance shares the stimulus to exercise beat-counter saturation.
module tb_systolic_skew_feeder;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXE = 4096;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid;
  logic            in_last;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_w;

  logic            in_ready, busy, done;
  logic [N-1:0]    lane_fire;
  logic [N*DW-1:0] lane_a, lane_w;
  logic [15:0]     tile_beats;

  logic            in_ready2, busy2, done2;
  logic [N-1:0]    lane_fire2;
  logic [N*DW-1:0] lane_a2, lane_w2;
  logic [1:0]      tile_beats2;

  systolic_skew_feeder #(.N(N), .DW(DW), .CW(16)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_a(in_a), .in_w(in_w), .lane_fire(lane_fire), .lane_a(lane_a), .lane_w(lane_w),
    .busy(busy), .done(done), .tile_beats(tile_beats)
  );

  systolic_skew_feeder #(.N(N), .DW(DW), .CW(2)) u_dut_c2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .in_a(in_a), .in_w(in_w), .lane_fire(lane_fire2), .lane_a(lane_a2), .lane_w(lane_w2),
    .busy(busy2), .done(done2), .tile_beats(tile_beats2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: per-edge input history plus tile bookkeeping.
  int              edge_k = 0;
  int              last_rst = 0;
  bit              hist_fire [MAXE];
  logic [N*DW-1:0] hist_a    [MAXE];
  logic [N*DW-1:0] hist_w    [MAXE];
  bit              m_pending = 1'b0;
  int              m_done_edge = 0;
  bit              m_tile_open = 1'b0;
  int              m_beats = 0;
  bit              m_ready = 1'b1;
  bit              m_busy = 1'b0;
  bit              m_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_k, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] ramp(input int base);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  task automatic step(input bit v, input bit l, input bit rn,
                      input logic [N*DW-1:0] a, input logic [N*DW-1:0] w);
    bit              acc, flushing, f;
    int              idx, sat16, sat2;
    logic [N-1:0]    e_fire;
    logic [N*DW-1:0] e_a, e_w, ha, hw;
    in_valid = v; in_last = l; rstn = rn; in_a = a; in_w = w;
    @(posedge clk);
    acc = rn && v && m_ready;
    edge_k++;
    hist_fire[edge_k] = acc;
    hist_a[edge_k]    = a;
    hist_w[edge_k]    = w;
    if (!rn) begin
      last_rst = edge_k; m_pending = 1'b0; m_tile_open = 1'b0; m_beats = 0;
    end else if (acc) begin
      m_beats = m_tile_open ? m_beats + 1 : 1;
      if (l) begin
        m_tile_open = 1'b0; m_pending = 1'b1; m_done_edge = edge_k + N - 1;
      end else begin
        m_tile_open = 1'b1;
      end
    end
    m_done   = m_pending && (edge_k == m_done_edge);
    flushing = m_pending && (edge_k < m_done_edge);
    if (m_pending && edge_k >= m_done_edge) m_pending = 1'b0;
    m_ready = !flushing;
    m_busy  = m_tile_open || flushing;
    for (int i = 0; i < N; i++) begin
      idx = edge_k - i;
      if (idx <= last_rst) begin
        e_fire[i] = 1'b0; e_a[i*DW +: DW] = '0; e_w[i*DW +: DW] = '0;
      end else begin
        f = hist_fire[idx]; ha = hist_a[idx]; hw = hist_w[idx];
        e_fire[i] = f;
        e_a[i*DW +: DW] = ha[i*DW +: DW];
        e_w[i*DW +: DW] = hw[i*DW +: DW];
`ifdef SYSTOLA_FEEDER_ZERO_GATE_EN
        if (!f) begin e_a[i*DW +: DW] = '0; e_w[i*DW +: DW] = '0; end
`endif
      end
    end
    sat16 = (m_beats > 65535) ? 65535 : m_beats;
    sat2  = (m_beats > 3) ? 3 : m_beats;
    #1;
    check("lane_fire", 64'(lane_fire), 64'(e_fire));
    check("lane_a", 64'(lane_a), 64'(e_a));
    check("lane_w", 64'(lane_w), 64'(e_w));
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("tile_beats", 64'(tile_beats), 64'(sat16));
    check("c2_tile_beats", 64'(tile_beats2), 64'(sat2));
    check("c2_lane_fire", 64'(lane_fire2), 64'(e_fire));
    check("c2_done", 64'(done2), 64'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, rand_vec(), rand_vec());
  endtask

  initial begin
    in_valid = 1'b0; in_last = 1'b0; rstn = 1'b0; in_a = '0; in_w = '0;
    #1;
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    check("reset_ready", 64'(in_ready), 64'(1));
    idle(2);

    // Three back-to-back beats, lane values 1..4, 5..8, 9..12.
    step(1'b1, 1'b0, 1'b1, ramp(1), ramp(101));
    step(1'b1, 1'b0, 1'b1, ramp(5), ramp(105));
    step(1'b1, 1'b1, 1'b1, ramp(9), ramp(109));
    idle(6);
    check("t1_tile_beats", 64'(tile_beats), 64'(3));

    // Single-beat tile from IDLE.
    step(1'b1, 1'b1, 1'b1, ramp(20), ramp(40));
    idle(6);
    check("t2_tile_beats", 64'(tile_beats), 64'(1));

    // Bubble mid-stream.
    step(1'b1, 1'b0, 1'b1, ramp(50), ramp(60));
    step(1'b0, 1'b0, 1'b1, ramp(70), ramp(80));
    step(1'b1, 1'b1, 1'b1, ramp(90), ramp(100));
    idle(6);

    // Valid held through FLUSH: next tile lands in the done cycle.
    step(1'b1, 1'b0, 1'b1, rand_vec(), rand_vec());
    step(1'b1, 1'b1, 1'b1, rand_vec(), rand_vec());
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, rand_vec(), rand_vec());
    step(1'b1, 1'b1, 1'b1, rand_vec(), rand_vec());
    idle(6);

    // Reset for one cycle in the middle of FLUSH.
    step(1'b1, 1'b0, 1'b1, rand_vec(), rand_vec());
    step(1'b1, 1'b1, 1'b1, rand_vec(), rand_vec());
    idle(1);
    step(1'b0, 1'b0, 1'b0, rand_vec(), rand_vec());
    check("rst_fire", 64'(lane_fire), 64'(0));
    idle(6);

    // Five-beat tile: CW=2 instance saturates at 3.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, rand_vec(), rand_vec());
    step(1'b1, 1'b1, 1'b1, rand_vec(), rand_vec());
    idle(6);
    check("sat_c2_beats", 64'(tile_beats2), 64'(3));
    check("sat_c16_beats", 64'(tile_beats), 64'(5));

    // Random traffic including stray in_last and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 80) != 0, rand_vec(), rand_vec());
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
